// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and the sequence detector benches:
// FSM state encoding, default widths and the default pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int SEQ_PAT_W = 5;
  localparam int SEQ_REP_W = 4;
  localparam int SEQ_GAP_W = 3;

  localparam logic [SEQ_PAT_W-1:0] SEQ_DEF_PAT = 5'b11011;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle between a pattern generator and its user.
// The slave side is the generator itself.
interface seq_pattern_gen_if
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int REP_W = SEQ_REP_W,
  parameter int GAP_W = SEQ_GAP_W
) ();

  logic             start;
  logic             use_def;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] repeats;
  logic [GAP_W-1:0] gap;
  logic             hold;
  logic             busy;
  logic             bit_out;
  logic             bit_valid;
  logic             last_bit;
  logic             done;

  modport master (
    output start, use_def, pattern, repeats, gap, hold,
    input  busy, bit_out, bit_valid, last_bit, done
  );

  modport slave (
    input  start, use_def, pattern, repeats, gap, hold,
    output busy, bit_out, bit_valid, last_bit, done
  );

endinterface

// File: rtl/seq_pattern_gen_piso.sv
// Parallel-load, MSB-first shift register. next_msb_o exposes the bit that will sit
// in the MSB after this edge, so the owner can register it alongside its own state.
module seq_piso #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         hold_i,
  input  logic [W-1:0] data_i,
  output logic         next_msb_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (hold_i) begin
      sr_d = sr_q;
    end else if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end else begin
      sr_d = sr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign next_msb_o = sr_d[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeats a captured pattern MSB-first with optional
// zero-fill gaps, qualified by bit_valid and flagged on each instance's final bit.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W,
  parameter int               REP_W   = SEQ_REP_W,
  parameter int               GAP_W   = SEQ_GAP_W,
  parameter logic [PAT_W-1:0] DEF_PAT = SEQ_DEF_PAT
) (
  input logic               clk,
  input logic               rst,
  seq_pattern_gen_if.slave  bus
);

  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  // state_q describes the item currently on the outputs; it only moves on advance_s.
  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;

  logic             advance_s;
  logic             load_s;
  logic             shift_s;
  logic [PAT_W-1:0] load_data_s;
  logic             next_msb_s;

  logic busy_q, busy_d;
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic last_bit_q, last_bit_d;
  logic done_q, done_d;

  assign advance_s = (state_q == IDLE) || !bus.hold;

  seq_piso #(.W(PAT_W)) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .shift_i    (shift_s),
    .hold_i     (!advance_s),
    .data_i     (load_data_s),
    .next_msb_o (next_msb_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_cfg_q <= '0;
      gcnt_q    <= '0;
      pat_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_cfg_q <= gap_cfg_d;
      gcnt_q    <= gcnt_d;
      pat_q     <= pat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    gap_cfg_d   = gap_cfg_q;
    gcnt_d      = gcnt_q;
    pat_d       = pat_q;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    load_data_s = pat_q;
    if (!advance_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && (bus.repeats != '0)) begin
            pat_d       = bus.use_def ? DEF_PAT : bus.pattern;
            load_data_s = pat_d;
            load_s      = 1'b1;
            idx_d       = IDX_MAX;
            rep_d       = bus.repeats;
            gap_cfg_d   = bus.gap;
            gcnt_d      = '0;
            state_d     = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (idx_q == '0) begin
            rep_d = rep_q - REP_W'(1);
            if (rep_d == '0) begin
              state_d = DONE;
            end else if (gap_cfg_q != '0) begin
              gcnt_d  = gap_cfg_q;
              state_d = GAP;
            end else begin
              idx_d   = IDX_MAX;
              load_s  = 1'b1;
              state_d = SHIFT;
            end
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            shift_s = 1'b1;
          end
        end
        GAP: begin
          if (gcnt_q == GAP_W'(1)) begin
            gcnt_d  = '0;
            idx_d   = IDX_MAX;
            load_s  = 1'b1;
            state_d = SHIFT;
          end else begin
            gcnt_d = gcnt_q - GAP_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the upcoming item; a frozen cycle shows only busy.
  always_comb begin
    busy_d      = 1'b0;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    done_d      = 1'b0;
    if (!advance_s) begin
      busy_d = 1'b1;
    end else begin
      case (state_d)
        IDLE: begin
          busy_d = 1'b0;
        end
        SHIFT: begin
          busy_d      = 1'b1;
          bit_valid_d = 1'b1;
          bit_out_d   = next_msb_s;
          last_bit_d  = (idx_d == '0);
        end
        GAP: begin
          busy_d      = 1'b1;
          bit_valid_d = 1'b1;
        end
        DONE: begin
          busy_d = 1'b1;
          done_d = 1'b1;
        end
        default: begin
          busy_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.last_bit  = last_bit_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed scenarios plus randomized transfers checked
// cycle by cycle against a queue of expected output items built from the pattern rules.
module tb_seq_pattern_gen;

  typedef struct packed {
    logic busy;
    logic bit_out;
    logic bit_valid;
    logic last_bit;
    logic done;
  } item_t;

  localparam logic [4:0] DEF = 5'b11011;

  logic clk;
  logic rst;
  seq_pattern_gen_if bus ();

  seq_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t       q[$];
  item_t       exp_s;
  item_t       obs_s;
  int          checks;
  int          failures;
  logic [63:0] stream;
  int          nvalid;
  int          nbusy;
  int          nlast;
  int          ndone;

  // Expected items for one accepted request: the bits, the gaps, the done cycle, then idle.
  function automatic void build();
    logic [4:0] p;
    int         reps;
    p    = bus.use_def ? DEF : bus.pattern;
    reps = int'(bus.repeats);
    for (int r = 0; r < reps; r++) begin
      for (int i = 4; i >= 0; i--) q.push_back({1'b1, p[i], 1'b1, (i == 0), 1'b0});
      if (r < reps - 1) begin
        for (int g = 0; g < int'(bus.gap); g++) q.push_back(5'b10100);
      end
    end
    q.push_back(5'b10001);
    q.push_back(5'b00000);
  endfunction

  task automatic clr();
    stream = '0;
    nvalid = 0;
    nbusy  = 0;
    nlast  = 0;
    ndone  = 0;
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, predict the next cycle, then compare on the falling edge.
  task automatic step(input logic st, input logic hd, input logic rs, input string tag);
    bus.start = st;
    bus.hold  = hd;
    rst       = rs;
    if (rs) begin
      q.delete();
      exp_s = 5'b00000;
    end else if (q.size() == 0) begin
      if (st && (bus.repeats != 4'd0)) begin
        build();
        exp_s = q.pop_front();
      end else begin
        exp_s = 5'b00000;
      end
    end else if (hd) begin
      exp_s = 5'b10000;
    end else begin
      exp_s = q.pop_front();
    end
    @(posedge clk);
    @(negedge clk);
    obs_s = {bus.busy, bus.bit_out, bus.bit_valid, bus.last_bit, bus.done};
    checks++;
    assert (obs_s === exp_s) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (busy,bit,valid,last,done)", tag, obs_s, exp_s);
    end
    if (obs_s.bit_valid) begin
      stream = {stream[62:0], obs_s.bit_out};
      nvalid++;
    end
    if (obs_s.busy)     nbusy++;
    if (obs_s.last_bit) nlast++;
    if (obs_s.done)     ndone++;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    bus.start   = 1'b0;
    bus.hold    = 1'b0;
    bus.use_def = 1'b0;
    bus.pattern = 5'b00000;
    bus.repeats = 4'd0;
    bus.gap     = 3'd0;
    rst         = 1'b1;
    clr();

    step(1'b0, 1'b0, 1'b1, "reset");
    step(1'b1, 1'b1, 1'b1, "reset_hold");
    step(1'b0, 1'b0, 1'b0, "post_reset");

    // Default pattern twice, back to back.
    bus.use_def = 1'b1;
    bus.pattern = 5'b00100;
    bus.repeats = 4'd2;
    bus.gap     = 3'd0;
    clr();
    step(1'b1, 1'b0, 1'b0, "def_x2");
    for (int c = 0; c < 13; c++) step(1'b0, 1'b0, 1'b0, "def_x2");
    check_val("def_x2_stream", int'(stream[9:0]), int'(10'b1101111011));
    check_val("def_x2_busy", nbusy, 11);
    check_val("def_x2_last", nlast, 2);
    check_val("def_x2_done", ndone, 1);

    // Explicit pattern with a two-bit gap.
    bus.use_def = 1'b0;
    bus.pattern = 5'b10110;
    bus.gap     = 3'd2;
    clr();
    step(1'b1, 1'b0, 1'b0, "gap2");
    for (int c = 0; c < 15; c++) step(1'b0, 1'b0, 1'b0, "gap2");
    check_val("gap2_stream", int'(stream[11:0]), int'(12'b101100010110));
    check_val("gap2_valid", nvalid, 12);
    check_val("gap2_done", ndone, 1);

    // Zero repeats: the request is ignored.
    bus.repeats = 4'd0;
    clr();
    step(1'b1, 1'b0, 1'b0, "rep0");
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, "rep0");
    check_val("rep0_busy", nbusy + nvalid + ndone, 0);

    // Three hold cycles after the third bit of 11011.
    bus.use_def = 1'b1;
    bus.repeats = 4'd1;
    bus.gap     = 3'd0;
    clr();
    step(1'b1, 1'b0, 1'b0, "hold");
    step(1'b0, 1'b0, 1'b0, "hold");
    step(1'b0, 1'b0, 1'b0, "hold");
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, "hold");
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0, "hold");
    check_val("hold_stream", int'(stream[4:0]), int'(5'b11011));
    check_val("hold_busy", nbusy, 9);

    // A second start mid-transfer, with different config, changes nothing.
    bus.use_def = 1'b0;
    bus.pattern = 5'b01101;
    bus.repeats = 4'd2;
    bus.gap     = 3'd1;
    clr();
    step(1'b1, 1'b0, 1'b0, "restart");
    for (int c = 0; c < 13; c++) begin
      if (c == 3) begin
        bus.pattern = 5'b11111;
        bus.repeats = 4'd5;
      end
      step((c == 3), 1'b0, 1'b0, "restart");
    end
    check_val("restart_stream", int'(stream[10:0]), int'(11'b01101001101));
    check_val("restart_busy", nbusy, 12);

    // Reset on the fourth bit, then a fresh start two cycles later.
    bus.pattern = 5'b10011;
    bus.repeats = 4'd1;
    bus.gap     = 3'd0;
    clr();
    step(1'b1, 1'b0, 1'b0, "rst_mid");
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, "rst_mid");
    step(1'b0, 1'b0, 1'b1, "rst_mid_reset");
    step(1'b0, 1'b0, 1'b0, "rst_mid_idle");
    check_val("rst_mid_done", ndone, 0);
    clr();
    step(1'b1, 1'b0, 1'b0, "rst_fresh");
    for (int c = 0; c < 7; c++) step(1'b0, 1'b0, 1'b0, "rst_fresh");
    check_val("rst_fresh_stream", int'(stream[4:0]), int'(5'b10011));
    check_val("rst_fresh_done", ndone, 1);

    // Randomized transfers with random holds, stray starts, config churn and rare resets.
    for (int t = 0; t < 25; t++) begin
      int guard;
      bus.use_def = 1'($urandom_range(0, 1));
      bus.pattern = 5'($urandom);
      bus.repeats = 4'($urandom_range(0, 15));
      bus.gap     = 3'($urandom_range(0, 7));
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, "rand_start");
      guard = 0;
      while (q.size() != 0 && guard < 2000) begin
        bus.pattern = 5'($urandom);
        bus.gap     = 3'($urandom);
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 299) == 0), "rand");
        guard++;
      end
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, "rand_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter that produces the bitstream consumed by the sequence detectors in the SEQUENCE DETECTOR block group. It captures a PAT_W-bit pattern and shifts it out MSB-first one bit per clock, repeated a programmable number of times, with optional zero-fill gaps between instances. It drives a per-bit valid qualifier and a `last_bit` flag. `last_bit` marks the exact cycle on which a matching overlapping Mealy detector must assert its output, so the block also serves as the stimulus source and scoreboard reference for detector benches.

## Interface
- PAT_W, 5: pattern width in bits (min 2).
- DEF_PAT, 5'b11011: pattern loaded when `use_def` is high at start.
- REP_W, 4: width of repeat counter.
- GAP_W, 3: width of gap counter.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- use_def  in  1  at start: 1 = DEF_PAT, 0 = `pattern`.
- pattern  in  PAT_W  pattern, MSB transmitted first.
- repeats  in  REP_W  number of pattern instances; 0 = request ignored.
- gap  in  GAP_W  zero bits inserted between instances (not after the last).
- hold  in  1  stall; freezes the block for that cycle.
- busy  out  1  transfer in progress.
- bit_out  out  1  serial data.
- bit_valid  out  1  bit_out carries a stream bit this cycle.
- last_bit  out  1  bit_out is the final bit of a pattern instance.
- done  out  1  one-cycle pulse after the final bit.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: if start=1 and repeats!=0, capture pattern (or DEF_PAT), repeats, and gap; load the shift register; bit index := PAT_W-1; go to SHIFT. In all other cases stay in IDLE.
- SHIFT: present pattern[idx] with bit_valid=1. last_bit=1 when idx=0. At idx=0:
  - decrement the remaining-repeat count;
  - remaining=0 → DONE;
  - else gap!=0 → GAP with gap counter := gap;
  - else reload idx and stay in SHIFT (back-to-back instances).
- GAP: bit_out=0, bit_valid=1, last_bit=0. Decrement the counter. At 1 → reload idx and go to SHIFT.
- DONE: done=1, busy=1, bit_valid=0 for one cycle, then IDLE.
- hold=1 (SHIFT/GAP/DONE): state, counters, and shift register are frozen. bit_valid=0, last_bit=0, done=0, bit_out=0. The pending bit is presented on the first cycle with hold=0. hold is ignored in IDLE.
- start while busy is ignored. Inputs other than hold are sampled only at capture.
- Counters are unsigned with no wrap-around. The repeat counter never decrements below 0 because DONE is entered on the final instance.

## Timing
- All outputs registered. Reset values: busy=0, bit_out=0, bit_valid=0, last_bit=0, done=0; state=IDLE; counters=0.
- start sampled high at edge k → first bit (MSB) valid in cycle k+1, busy=1 from k+1.
- Without hold, total busy cycles = repeats·PAT_W + (repeats−1)·gap + 1.
- done is asserted in the cycle after the final last_bit. busy drops in the following cycle, and a new start is accepted from that cycle.
- rst during a transfer takes priority over everything. The next cycle shows reset values, and no done pulse is produced.
- hold and start in the same IDLE cycle: start is taken.

## Structure
- Shared package `seq_pkg`: state enum (IDLE, SHIFT, GAP, DONE), DEF_PAT constant, and default widths, also reused by detector benches.
- One natural sub-module, `seq_piso`: a PAT_W parallel-load, MSB-first shift register with load/shift/hold enables. The FSM and counters stay in `seq_pattern_gen`.
- Target 150–250 lines total.

## Test plan
- DEF_PAT, repeats=2, gap=0, start at k → bits 1101111011 on k+1..k+10, last_bit at k+5 and k+10, done at k+11, busy low at k+12; a detector for 11011 fires at k+5 and k+10.
- pattern=10110, repeats=2, gap=2 → 10110 00 10110, bit_valid high for 12 cycles, last_bit at the 5th and 12th valid bits, done one cycle later.
- repeats=0 with start=1 → busy, bit_valid, and done stay 0 for 10 cycles.
- hold high for 3 cycles after the 3rd bit of 11011 → bit_valid=0 during hold, the stream resumes with bit 4 (=1), and the total busy time extends by exactly 3 cycles.
- start pulsed again mid-transfer → ignored; the stream and done timing are identical to the single-start case.
- rst asserted on the 4th bit → next cycle all outputs are 0 and state is IDLE, no done pulse; a fresh start two cycles later transmits the full pattern from the MSB.
